regfile_writeback_sink: RTL
===========================

# regfile_writeback_sink

Integer register file on the receiving end of the writeback stage. It takes the selected result, destination index and write enable from writeback and commits them to a 32 x 32-bit architectural register array. It serves the two combinational source-operand read ports used by decode. x0 is hardwired to zero. An optional internal write-to-read bypass removes the WB-to-ID hazard without a stall.

## Interface
Parameters:
- `XLEN`, 32: register width in bits.
- `NREGS`, 32: number of architectural registers. The index width is log2(`NREGS`) = 5.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `RegWrite_W` input 1: write enable from the writeback stage.
- `Rd_W` input 5: destination register index from writeback.
- `Result_W` input `XLEN`: write data, i.e. the ALU, memory or PC+4 result chosen by writeback.
- `A1_D` input 5: source register 1 index from decode.
- `A2_D` input 5: source register 2 index from decode.
- `RD1_D` output `XLEN`: read data for `A1_D`.
- `RD2_D` output `XLEN`: read data for `A2_D`.
- `WrCommit_W` output 1: registered pulse. It is 1 for the cycle after a write has actually been committed.

## Operation
- **Storage:** registers x1..x31 are flops. x0 has no storage and always reads 0.
- **Write qualification:** a write is qualified when `RegWrite_W`=1, `rst`=0 and `Rd_W`!=0. When qualified, `regs[Rd_W]` <= `Result_W` at the rising edge. Unqualified writes change nothing.
- **Writes to x0:** these are silently dropped. `WrCommit_W` stays 0 for them.
- **Reads:** both ports are fully combinational from their index.
  - Index 0 returns 0.
  - Otherwise the port returns `regs[index]`, or the bypassed value (see Configuration).
- **Port independence:** `A1_D` equal to `A2_D` is legal. Both ports return the same value.
- **During reset:** while `rst`=1, `RD1_D` and `RD2_D` are forced to 0 and no write occurs.
- **Reset:**
  - Sampled at the rising edge.
  - Clears every register to 0 and clears `WrCommit_W` to 0.
  - A write presented in the same cycle as `rst`=1 is discarded.
  - Reset asserted mid-program leaves all registers at 0 from the next edge on.
- **X handling:** `Result_W` containing X is stored as-is. This block does not sanitise data.
- **Width:** there is no extension or truncation. `Result_W` is stored bit-for-bit.

## Timing
- **Write latency:** data is visible in the array one edge after qualification. The read path sees it in the cycle after the edge, with or without bypass.
- **Read latency:** zero cycles, combinational from `A1_D`/`A2_D` and the array.
- **`WrCommit_W`:** asserts in cycle N+1 for a write qualified in cycle N, for exactly one cycle per write. Back-to-back writes produce a continuous high.
- **Reset values:** all outputs are 0 while `rst`=1. All array entries are 0 after the reset edge.
- **Simultaneous write and read, same index, same cycle:** the result depends on the bypass option (see Configuration).
- **Simultaneous write and read, different index:** the read returns the stored value, unaffected by the write.

## Configuration
- **Macro:** `REGFILE_WB_BYPASS_EN`.
- **Defined:**
  - If a qualified write targets `A1_D` (or `A2_D`) in the same cycle, that read port returns `Result_W` combinationally.
  - Index 0 is never bypassed and reads 0.
  - Decode therefore reads a value being written back in the same cycle, and the hazard unit needs no WB-to-ID stall.
- **Undefined:**
  - No bypass. A same-cycle read of `Rd_W` returns the old stored value.
  - The new value appears from the next cycle on.
  - The hazard unit must then stall decode one cycle on a WB-to-ID match.

## Test plan
- **Reset clear:** preload x5=0xDEADBEEF, then hold `rst`=1 for one edge. Expect x5 to read 0, `RD1_D`=`RD2_D`=0 during reset, and `WrCommit_W`=0.
- **Basic write/read:** `RegWrite_W`=1, `Rd_W`=7, `Result_W`=0x12345678, then `A1_D`=7 next cycle. Expect `RD1_D`=0x12345678 and a one-cycle `WrCommit_W` pulse.
- **x0 protection:** write 0xFFFFFFFF to `Rd_W`=0, then `A1_D`=`A2_D`=0. Expect both ports = 0 and `WrCommit_W`=0.
- **Same-cycle hazard:** x3 holds 0x11. Write 0x22 to x3 while `A2_D`=3 in the same cycle.
  - With `REGFILE_WB_BYPASS_EN`: `RD2_D`=0x22.
  - Without it: `RD2_D`=0x11, then 0x22 in the next cycle.
- **Write during reset:** `rst`=1 together with `RegWrite_W`=1, `Rd_W`=9, `Result_W`=0xAA. Expect x9=0 after reset releases and no `WrCommit_W` pulse.
- **Back-to-back writes:** write x1=1, x2=2, x1=3 in consecutive cycles. Expect x1=3, x2=2, and `WrCommit_W` high for three consecutive cycles.

Source files
------------

// File: rtl/regfile_writeback_sink.sv
// ============================================================================
// Module   : regfile_writeback_sink
// Brief    : 32 x XLEN integer register file at the end of the writeback
//            stage. One synchronous write port fed by writeback and two
//            combinational read ports serving decode. x0 is hardwired to 0.
//
// Ports    : clk         - clock, all state changes on the rising edge
//            rst         - synchronous active-high reset
//            RegWrite_W  - write enable from writeback
//            Rd_W        - destination register index
//            Result_W    - write data (ALU / memory / PC+4 result)
//            A1_D        - decode source-1 index
//            A2_D        - decode source-2 index
//            RD1_D       - read data for A1_D (combinational)
//            RD2_D       - read data for A2_D (combinational)
//            WrCommit_W  - one-cycle pulse the cycle after a committed write
//
// Options  : REGFILE_WB_BYPASS_EN - when defined, a qualified write to the
//            index being read in the same cycle is forwarded from Result_W
//            to the read port, so decode never sees the stale value.
//
// Revision : 1.0 - initial release
// ============================================================================

`default_nettype none

module regfile_writeback_sink #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     RegWrite_W,
    input  logic [$clog2(NREGS)-1:0] Rd_W,
    input  logic [XLEN-1:0]          Result_W,
    input  logic [$clog2(NREGS)-1:0] A1_D,
    input  logic [$clog2(NREGS)-1:0] A2_D,
    output logic [XLEN-1:0]          RD1_D,
    output logic [XLEN-1:0]          RD2_D,
    output logic                     WrCommit_W
);

    localparam int c_AW = $clog2(NREGS);

    // Flattened view of the array; entry 0 is a constant, the rest are flops.
    logic [XLEN-1:0] w_rf [NREGS];

    // A write takes effect only outside reset and never for x0.
    logic w_wr_qual;
    assign w_wr_qual = RegWrite_W && !rst && (Rd_W != '0);

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_x0
                assign w_rf[gi] = '0;
            end else begin : g_xn
                logic [XLEN-1:0] r_q;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_q <= '0;
                    end else if (w_wr_qual && (Rd_W == c_AW'(gi))) begin
                        r_q <= Result_W;
                    end
                end

                assign w_rf[gi] = r_q;
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Commit pulse: registered copy of the qualification, so back-to-back
    // writes naturally hold it high.
    // ------------------------------------------------------------------------
    logic r_wr_commit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_commit <= 1'b0;
        end else begin
            r_wr_commit <= w_wr_qual;
        end
    end

    assign WrCommit_W = r_wr_commit;

    // ------------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------------
    logic [XLEN-1:0] w_rd1;
    logic [XLEN-1:0] w_rd2;

    always_comb begin
        w_rd1 = '0;
        // Outputs are held at zero while reset is asserted, regardless of
        // whatever the array happens to contain before the clearing edge.
        if (!rst && (A1_D != '0)) begin
            w_rd1 = w_rf[A1_D];
`ifdef REGFILE_WB_BYPASS_EN
            // w_wr_qual already excludes x0, so index 0 can never be bypassed.
            if (w_wr_qual && (Rd_W == A1_D)) begin
                w_rd1 = Result_W;
            end
`endif
        end
    end

    always_comb begin
        w_rd2 = '0;
        if (!rst && (A2_D != '0)) begin
            w_rd2 = w_rf[A2_D];
`ifdef REGFILE_WB_BYPASS_EN
            if (w_wr_qual && (Rd_W == A2_D)) begin
                w_rd2 = Result_W;
            end
`endif
        end
    end

    assign RD1_D = w_rd1;
    assign RD2_D = w_rd2;

endmodule

`default_nettype wire
